// File: rtl/servo_arbiter.sv
// -----------------------------------------------------------------------------
// servo_arbiter
//
// Two requesters share one servo. A winner's target angle is latched at grant
// and clamped to MAX_ANGLE. The commanded angle then slews one degree every
// STEP_DIV clock cycles until it reaches the target. Completion is signalled
// with a single-cycle acknowledge to the owning requester.
//
// Optional feature (compile-time macro SERVO_ARB_ROUND_ROBIN_EN):
//   defined   -> simultaneous requests alternate between A and B.
//   undefined -> fixed priority; A always wins a tie.
//
// Parameters
//   STEP_DIV   clock cycles per 1-degree step (1 .. 2^20)
//   MAX_ANGLE  upper angle limit in degrees (<= 255)
//   INIT_ANGLE oAngle value after reset
//
// Ports
//   Clk      in   system clock, rising edge
//   iRst     in   synchronous active-high reset
//   iReqA    in   requester A move request, held until oAckA
//   iAngleA  in   requester A target angle, sampled at grant only
//   iReqB    in   requester B move request, held until oAckB
//   iAngleB  in   requester B target angle, sampled at grant only
//   oAngle   out  current commanded servo angle (registered)
//   oAckA    out  one-cycle pulse, A's move complete
//   oAckB    out  one-cycle pulse, B's move complete
//   oBusy    out  high while a move is in progress or completing
//   oGrant   out  owner of the current/last move (0 = A, 1 = B)
// -----------------------------------------------------------------------------
module servo_arbiter #(
  parameter int unsigned STEP_DIV   = 50000,
  parameter int unsigned MAX_ANGLE  = 180,
  parameter int unsigned INIT_ANGLE = 90
) (
  input  logic       Clk,
  input  logic       iRst,
  input  logic       iReqA,
  input  logic [7:0] iAngleA,
  input  logic       iReqB,
  input  logic [7:0] iAngleB,
  output logic [7:0] oAngle,
  output logic       oAckA,
  output logic       oAckB,
  output logic       oBusy,
  output logic       oGrant
);

  localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [7:0]       MAX_A    = 8'(MAX_ANGLE);
  localparam logic [7:0]       INIT_A   = 8'(INIT_ANGLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [7:0]       r_angle;
  logic [7:0]       r_target;
  logic [CNT_W-1:0] r_cnt;
  logic             r_grant;

  logic             w_any_req;
  logic             w_win_b;
  logic [7:0]       w_req_angle;
  logic [7:0]       w_clamped;
  logic             w_at_target;
  logic             w_step_tick;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign w_any_req = iReqA | iReqB;

`ifdef SERVO_ARB_ROUND_ROBIN_EN
  // r_rr_b set means B is favoured on the next tie. Reset favours A.
  logic r_rr_b;

  assign w_win_b = iReqB & (~iReqA | r_rr_b);

  always_ff @(posedge Clk) begin
    if (iRst) begin
      r_rr_b <= 1'b0;
    end else if ((r_state == S_IDLE) && w_any_req) begin
      // Favour whoever did not just win.
      r_rr_b <= ~w_win_b;
    end
  end
`else
  assign w_win_b = iReqB & ~iReqA;
`endif

  assign w_req_angle = w_win_b ? iAngleB : iAngleA;
  assign w_clamped   = (w_req_angle > MAX_A) ? MAX_A : w_req_angle;
  assign w_at_target = (r_angle == r_target);
  assign w_step_tick = (r_cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge value of every other register, independent of block order.
  always_ff @(posedge Clk) begin
    if (iRst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and decoded outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default at the top of the block; any path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    oAckA        = 1'b0;
    oAckB        = 1'b0;
    oBusy        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_next_state = S_MOVE;
        end
      end
      S_MOVE: begin
        oBusy = 1'b1;
        if (w_at_target) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        oBusy        = 1'b1;
        oAckA        = ~r_grant;
        oAckB        = r_grant;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: target latch, owner, step counter, commanded angle
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (iRst) begin
      r_angle  <= INIT_A;
      r_target <= INIT_A;
      r_cnt    <= '0;
      r_grant  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_target <= w_clamped;
            r_grant  <= w_win_b;
            r_cnt    <= '0;
          end
        end
        S_MOVE: begin
          if (!w_at_target) begin
            if (w_step_tick) begin
              r_cnt <= '0;
              // Target is clamped to 0..MAX_ANGLE and the angle only moves
              // toward it, so neither direction can wrap.
              if (r_angle < r_target) begin
                r_angle <= r_angle + 8'd1;
              end else begin
                r_angle <= r_angle - 8'd1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign oAngle = r_angle;
  assign oGrant = r_grant;

endmodule

// File: tb/tb_servo_arbiter.sv
// -----------------------------------------------------------------------------
// tb_servo_arbiter
//
// Directed bench for servo_arbiter with STEP_DIV = 4, MAX_ANGLE = 180,
// INIT_ANGLE = 90. Stimulus pushes the expected acknowledge (owner, final
// angle, cycle of the ack) into a scoreboard queue; an independent monitor
// pops and compares whenever an ack appears. The stimulus side also checks the
// slewing trajectory, busy and grant, and the reset behaviour.
// -----------------------------------------------------------------------------
module tb_servo_arbiter;

  localparam int STEP  = 4;
  localparam int MAXA  = 180;
  localparam int INITA = 90;

  logic       Clk = 1'b0;
  logic       iRst = 1'b0;
  logic       iReqA = 1'b0;
  logic [7:0] iAngleA = '0;
  logic       iReqB = 1'b0;
  logic [7:0] iAngleB = '0;
  logic [7:0] oAngle;
  logic       oAckA;
  logic       oAckB;
  logic       oBusy;
  logic       oGrant;

  servo_arbiter #(
    .STEP_DIV   (STEP),
    .MAX_ANGLE  (MAXA),
    .INIT_ANGLE (INITA)
  ) dut (
    .Clk     (Clk),
    .iRst    (iRst),
    .iReqA   (iReqA),
    .iAngleA (iAngleA),
    .iReqB   (iReqB),
    .iAngleB (iAngleB),
    .oAngle  (oAngle),
    .oAckA   (oAckA),
    .oAckB   (oAckB),
    .oBusy   (oBusy),
    .oGrant  (oGrant)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    bit is_b;
    int angle;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_en   = 1'b0;
  int  m_angle  = INITA;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input bit is_b, input int angle, input int ack_cyc);
    exp_t e;
    e.is_b  = is_b;
    e.angle = angle;
    e.cyc   = ack_cyc;
    sb_q.push_back(e);
  endtask

  // Monitor: invariants every cycle, scoreboard compare on every ack.
  always @(negedge Clk) begin
    if (mon_en) begin
      check("ack_exclusive", int'(oAckA & oAckB), 0);
      check("angle_le_max", int'(oAngle <= 8'(MAXA)), 1);
      if (oAckA | oAckB) begin
        if (sb_q.size() == 0) begin
          check("ack_unexpected", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("ack_owner", int'(oAckB), int'(mon_e.is_b));
          check("ack_grant", int'(oGrant), int'(mon_e.is_b));
          check("ack_angle", int'(oAngle), mon_e.angle);
          check("ack_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic do_reset();
    iRst  = 1'b1;
    iReqA = 1'b0;
    iReqB = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    iRst    = 1'b0;
    m_angle = INITA;
  endtask

  // Wait for the next ack (bounded); returns the cycle it was seen in.
  task automatic wait_ack(input int budget, output int c, output bit ok);
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge Clk);
      #1;
      if (oAckA | oAckB) begin
        ok = 1'b1;
        c  = cyc;
      end
    end
    if (!ok) check("ack_timeout", 0, 1);
  endtask

  // Single-requester move from IDLE, with trajectory checks on the way.
  task automatic do_move(input bit is_b, input int ang, input bit drop_mid);
    int fin, d, k, start, n, steps, exp_a;
    bit seen;
    fin   = (ang > MAXA) ? MAXA : ang;
    start = m_angle;
    d     = (fin > start) ? fin - start : start - fin;
    k     = cyc;
    if (is_b) begin
      iReqB   = 1'b1;
      iAngleB = 8'(ang);
    end else begin
      iReqA   = 1'b1;
      iAngleA = 8'(ang);
    end
    push_exp(is_b, fin, k + 2 + STEP * d);
    seen = 1'b0;
    for (int i = 0; i < STEP * d + 20 && !seen; i++) begin
      @(posedge Clk);
      #1;
      n = cyc - (k + 1);
      if (drop_mid && n == 10) begin
        iReqA   = 1'b0;
        iReqB   = 1'b0;
        iAngleA = 8'd0;
        iAngleB = 8'd0;
      end
      if (oAckA | oAckB) begin
        seen  = 1'b1;
        iReqA = 1'b0;
        iReqB = 1'b0;
      end else begin
        steps = (n / STEP < d) ? n / STEP : d;
        exp_a = (fin >= start) ? start + steps : start - steps;
        check("move_angle", int'(oAngle), exp_a);
        check("move_busy", int'(oBusy), 1);
        check("move_grant", int'(oGrant), int'(is_b));
      end
    end
    if (!seen) begin
      check("ack_timeout", 0, 1);
      iReqA = 1'b0;
      iReqB = 1'b0;
    end
    @(posedge Clk);
    #1;
    check("post_busy", int'(oBusy), 0);
    check("post_angle", int'(oAngle), fin);
    m_angle = fin;
  endtask

  initial begin
    int  c1, c2, k;
    bit  ok;

    // Reset state
    iRst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_angle", int'(oAngle), INITA);
    check("rst_busy", int'(oBusy), 0);
    check("rst_ackA", int'(oAckA), 0);
    check("rst_ackB", int'(oAckB), 0);
    check("rst_grant", int'(oGrant), 0);
    iRst    = 1'b0;
    mon_en  = 1'b1;
    m_angle = INITA;

    // Zero-distance move: ack in third cycle, angle stays put
    do_move(1'b0, 90, 1'b0);
    // Three steps up at 4-cycle intervals
    do_move(1'b0, 93, 1'b0);
    // Requester drops and changes angle mid-move; move still completes
    do_move(1'b0, 100, 1'b1);
    // Long move to 178, then B asks for 250 -> clamped at 180
    do_move(1'b0, 178, 1'b0);
    do_move(1'b1, 250, 1'b0);
    // B moves down
    do_move(1'b1, 170, 1'b0);

    // Reset mid-move at 95 on the way to 120: no ack, back to 90
    do_reset();
    iReqA   = 1'b1;
    iAngleA = 8'd120;
    ok      = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge Clk);
      #1;
      if (oAngle == 8'd95) ok = 1'b1;
    end
    check("reach_95", int'(ok), 1);
    iRst = 1'b1;
    @(posedge Clk);
    #1;
    iRst  = 1'b0;
    iReqA = 1'b0;
    check("midrst_angle", int'(oAngle), INITA);
    check("midrst_busy", int'(oBusy), 0);
    check("midrst_grant", int'(oGrant), 0);
    check("midrst_ackA", int'(oAckA), 0);
    repeat (8) @(posedge Clk);
    #1;
    check("midrst_idle", int'(oBusy), 0);
    check("midrst_hold", int'(oAngle), INITA);
    m_angle = INITA;

    // Simultaneous requests twice in succession
    do_reset();
    iReqA   = 1'b1;
    iReqB   = 1'b1;
    iAngleA = 8'd92;
    iAngleB = 8'd88;
    k = cyc;
    push_exp(1'b0, 92, k + 2 + STEP * 2);
    wait_ack(100, c1, ok);
    // Both requests stay high: a fresh tie for the next IDLE cycle
`ifdef SERVO_ARB_ROUND_ROBIN_EN
    push_exp(1'b1, 88, c1 + 3 + STEP * 4);
`else
    push_exp(1'b0, 92, c1 + 3);
`endif
    wait_ack(100, c2, ok);
    iReqA = 1'b0;
    iReqB = 1'b0;
    @(posedge Clk);
    #1;
    check("tie_post_busy", int'(oBusy), 0);
`ifdef SERVO_ARB_ROUND_ROBIN_EN
    check("tie_final_angle", int'(oAngle), 88);
`else
    check("tie_final_angle", int'(oAngle), 92);
`endif

    repeat (5) @(posedge Clk);
    #1;
    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/servo_arbiter.md
SERVO_ARBITER -- requirements
Module: servo_arbiter

Interface
REQ-001 Parameter STEP_DIV, default 50000: clock cycles per 1-degree step of oAngle; legal range 1..2^20.
REQ-002 Parameter MAX_ANGLE, default 180: upper angle limit in degrees.
REQ-003 Parameter INIT_ANGLE, default 90: oAngle value after reset.
REQ-004 Clk  input  1  single system clock; all logic on rising edge.
REQ-005 iRst  input  1  synchronous, active-high reset.
REQ-006 iReqA  input  1  requester A (manual UI) move request; held high until oAckA.
REQ-007 iAngleA  input  8  requester A target angle, sampled only at grant.
REQ-008 iReqB  input  1  requester B (preset sequencer) move request; held high until oAckB.
REQ-009 iAngleB  input  8  requester B target angle, sampled only at grant.
REQ-010 oAngle  output  8  current commanded servo angle, registered.
REQ-011 oAckA  output  1  one-cycle pulse: A's move complete.
REQ-012 oAckB  output  1  one-cycle pulse: B's move complete.
REQ-013 oBusy  output  1  high in MOVE and DONE states.
REQ-014 oGrant  output  1  owner of current/last move: 0 = A, 1 = B.

Function
REQ-015 FSM states IDLE, MOVE, DONE, registered; encoding free.
REQ-016 IDLE: if iReqA or iReqB high, arbitrate, latch winner's angle as target, set oGrant, clear step counter, go MOVE next cycle; else stay IDLE.
REQ-017 Target clamp: latched angle > MAX_ANGLE -> target = MAX_ANGLE.
REQ-018 MOVE: if oAngle == target -> DONE next cycle; else step counter increments each cycle, and on reaching STEP_DIV-1 it clears and oAngle moves 1 toward target.
REQ-019 oAngle never exceeds MAX_ANGLE nor drops below 0; no wrap-around.
REQ-020 DONE: assert oAckA (oGrant=0) or oAckB (oGrant=1) for exactly this one cycle, then IDLE.
REQ-021 Latency: target == oAngle -> ack in 3rd cycle after req sampled (IDLE, MOVE, DONE); otherwise ack after |target - oAngle| * STEP_DIV + 2 further cycles.
REQ-022 Requester deasserting mid-move: move still completes and ack still pulses; no abort.
REQ-023 Request present in the DONE cycle or later is arbitrated in the following IDLE cycle; minimum 1 IDLE cycle between moves.
REQ-024 iAngleA/iAngleB changes during MOVE ignored.
REQ-025 Both acks never high together; oAckx only in DONE.

Reset
REQ-026 iRst high at any clock edge, including mid-MOVE: state IDLE, oAngle = INIT_ANGLE, step counter 0, oAckA = oAckB = 0, oBusy = 0, oGrant = 0, round-robin pointer favours A.
REQ-027 Reset overrides all other inputs in the same cycle; no ack for an aborted move.

Configuration
REQ-028 Macro SERVO_ARB_ROUND_ROBIN_EN defined: simultaneous iReqA and iReqB in IDLE go to the requester not granted last; pointer updates at each grant.
REQ-029 Macro undefined: fixed priority, A always wins on simultaneous requests; no pointer logic.
REQ-030 Single request behaviour identical in both builds.

Verification (STEP_DIV = 4, MAX_ANGLE = 180, INIT_ANGLE = 90)
REQ-031 Reset, then iReqA=1, iAngleA=93 -> oAngle 91, 92, 93 at 4-cycle intervals; oAckA one pulse 14 cycles after request sampled; oBusy low after.
REQ-032 iReqB=1, iAngleB=250 from oAngle 178 -> oAngle stops at 180, oAckB pulses, never 181.
REQ-033 iReqA and iReqB both high twice in succession -> with SERVO_ARB_ROUND_ROBIN_EN grants A then B; without it A then A (B starved while A held).
REQ-034 iReqA=1, iAngleA=90 right after reset -> oAckA in 3rd cycle, oAngle stays 90.
REQ-035 iRst pulsed mid-move at oAngle 95 toward 120 -> next cycle oAngle = 90, state IDLE, no ack issued.
REQ-036 iReqA dropped and iAngleA changed to 0 mid-move to 100 -> oAngle still reaches 100 and oAckA pulses once.
